// File: rtl/sli_seq_pkg.sv
// Shared state encoding and frame-index constants for the SLI frame sequencer.
package sli_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LUT = 2'd0,
    RUN      = 2'd1,
    PASS     = 2'd2,
    ST_BAD   = 2'd3
  } state_t;

  localparam int NUM_FRA = 8;
  localparam int NUM_FRQ = 4;
  localparam int FRA_W   = $clog2(NUM_FRA);
  localparam int FRQ_W   = $clog2(NUM_FRQ);

endpackage

// File: rtl/sync_edge.sv
// Optional 2-FF synchronizer followed by a registered rising-edge detector.
// SYNC_EN=0 keeps only the edge-detect stage for inputs already in the clk domain.
module sync_edge #(
  parameter bit SYNC_EN = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic rise
);

  logic s_in;
  logic prev_reg;
  logic rise_reg;

  generate
    if (SYNC_EN) begin : g_sync
      logic [1:0] sync_reg;
      always_ff @(posedge clk) begin
        if (!rstn) sync_reg <= '0;
        else       sync_reg <= {sync_reg[0], d};
      end
      assign s_in = sync_reg[1];
    end else begin : g_bypass
      assign s_in = d;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rstn) begin
      prev_reg <= 1'b0;
      rise_reg <= 1'b0;
    end else begin
      prev_reg <= s_in;
      rise_reg <= s_in & ~prev_reg;
    end
  end

  assign rise = rise_reg;

endmodule

// File: rtl/sli_frame_sequencer.sv
// Structured-light frame sequencer: steps frequency/phase indices per credited vsync
// and fires the camera trigger. Define SLI_REPEAT_EN to hold each pattern REPEAT frames.
module sli_frame_sequencer
  import sli_seq_pkg::*;
#(
  parameter int RDY_CNT_W = 4,
  parameter int TRIG_LEN  = 16,
  parameter int REPEAT    = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_vsync,
  input  logic             rdy,
  input  logic             mode,
  input  logic             ori,
  input  logic             lut_rdy,
  input  logic             tl_change,
  output logic [FRQ_W-1:0] frq,
  output logic [FRA_W-1:0] fra,
  output logic             ori_out,
  output logic             trig,
  output logic             f_frm,
  output logic [1:0]       state,
  output logic             ovf
);

  localparam logic [RDY_CNT_W-1:0] CNT_MAX = '1;

  state_t               state_reg, state_next;
  logic [FRQ_W-1:0]     frq_reg, frq_next;
  logic [FRA_W-1:0]     fra_reg, fra_next;
  logic                 ori_reg, ori_next;
  logic [RDY_CNT_W-1:0] cnt_reg, cnt_next;
  logic                 ovf_reg, ovf_next;
  logic                 pend_reg, pend_next;
  logic [7:0]           trig_cnt_reg, trig_cnt_next;

  logic vs_edge, rdy_edge;
  logic fire, clr_idx, credited, rep_done, advance;

  sync_edge #(.SYNC_EN(1'b1)) u_rdy_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (rdy),
    .rise (rdy_edge)
  );

  sync_edge #(.SYNC_EN(1'b0)) u_vs_edge (
    .clk  (clk),
    .rstn (rstn),
    .d    (in_vsync),
    .rise (vs_edge)
  );

  // A vsync that would step the pattern: running, no orientation change, credit available.
  assign credited = (state_reg == RUN) && lut_rdy && vs_edge && mode &&
                    (ori == ori_reg) && (cnt_reg != '0);

`ifdef SLI_REPEAT_EN
  logic [1:0] rep_reg;

  assign rep_done = (rep_reg == 2'(REPEAT - 1));

  always_ff @(posedge clk) begin
    if (!rstn || clr_idx) rep_reg <= '0;
    else if (credited)    rep_reg <= rep_done ? 2'd0 : rep_reg + 2'd1;
  end
`else
  // Every legal REPEAT is >= 1, so each credited vsync advances.
  assign rep_done = (REPEAT >= 1);
`endif

  assign advance = credited & rep_done;

  always_comb begin
    state_next = state_reg;
    ori_next   = ori_reg;
    cnt_next   = cnt_reg;
    ovf_next   = ovf_reg;
    pend_next  = pend_reg;
    frq_next   = frq_reg;
    fra_next   = fra_reg;
    fire       = 1'b0;
    clr_idx    = 1'b0;

    case (state_reg)
      WAIT_LUT: begin
        pend_next = 1'b0;
        if (vs_edge && lut_rdy) begin
          if (mode) begin
            state_next = RUN;
            clr_idx    = 1'b1;
            fire       = 1'b1;
          end else begin
            state_next = PASS;
          end
        end
      end
      RUN: begin
        pend_next = 1'b0;
        if (!lut_rdy) begin
          state_next = WAIT_LUT;
        end else if (vs_edge) begin
          if (!mode) begin
            state_next = PASS;
          end else if (ori != ori_reg) begin
            ori_next = ori;
            clr_idx  = 1'b1;
            fire     = 1'b1;
          end else if (advance) begin
            fire = 1'b1;
          end
        end
        // A consumed credit and a new rdy edge in the same cycle cancel out.
        if (rdy_edge && !advance) begin
          if (cnt_reg == CNT_MAX) ovf_next = 1'b1;
          else                    cnt_next = cnt_reg + 1'b1;
        end else if (!rdy_edge && advance) begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      PASS: begin
        cnt_next = '0;
        if (tl_change) pend_next = 1'b1;
        if (!lut_rdy) begin
          state_next = WAIT_LUT;
        end else if (vs_edge) begin
          if (pend_reg) begin
            fire      = 1'b1;
            pend_next = tl_change;
          end
          if (mode) begin
            state_next = RUN;
            clr_idx    = 1'b1;
          end
        end
      end
      default: state_next = WAIT_LUT;
    endcase

    if (clr_idx) begin
      frq_next = '0;
      fra_next = '0;
    end else if (advance) begin
      if (fra_reg == FRA_W'(NUM_FRA - 1)) begin
        fra_next = '0;
        frq_next = (frq_reg == FRQ_W'(NUM_FRQ - 1)) ? '0 : frq_reg + 1'b1;
      end else begin
        fra_next = fra_reg + 1'b1;
      end
    end
  end

  always_comb begin
    trig_cnt_next = trig_cnt_reg;
    if (fire)                    trig_cnt_next = 8'(TRIG_LEN);
    else if (trig_cnt_reg != '0) trig_cnt_next = trig_cnt_reg - 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg    <= WAIT_LUT;
      frq_reg      <= '0;
      fra_reg      <= '0;
      ori_reg      <= 1'b0;
      cnt_reg      <= '0;
      ovf_reg      <= 1'b0;
      pend_reg     <= 1'b0;
      trig_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      frq_reg      <= frq_next;
      fra_reg      <= fra_next;
      ori_reg      <= ori_next;
      cnt_reg      <= cnt_next;
      ovf_reg      <= ovf_next;
      pend_reg     <= pend_next;
      trig_cnt_reg <= trig_cnt_next;
    end
  end

  assign frq     = frq_reg;
  assign fra     = fra_reg;
  assign ori_out = ori_reg;
  assign trig    = (trig_cnt_reg != '0);
  assign f_frm   = (frq_reg == '0) && (fra_reg == '0);
  assign state   = state_reg;
  assign ovf     = ovf_reg;

endmodule
